// File: rtl/dm_axi_master.sv
// Data-memory AXI master: turns one MEM-stage load/store into a single-beat
// AXI transaction and stalls the pipeline via DM_busy until it completes.
module dm_axi_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        DM_busy,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;

    // Error responses complete like OKAY, so the resp codes are not consumed.
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};

    // Valids/readies decode from registered state only: no ready->valid path.
    assign arvalid = (state == RD_ADDR);
    assign rready  = (state == RD_DATA);
    assign awvalid = (state == WR_REQ) && !aw_done;
    assign wvalid  = (state == WR_REQ) && !w_done;
    assign bready  = (state == WR_RESP);

    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    assign DM_busy = ((state != IDLE) && (state != DONE)) ||
                     ((state == IDLE) && (mem_re || mem_we));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            mem_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_re || mem_we) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        // A simultaneous store request is dropped.
                        state   <= mem_re ? RD_ADDR : WR_REQ;
                    end
                end
                RD_ADDR: begin
                    if (arready) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (rvalid) begin
                        mem_rdata <= rdata;
                        state     <= DONE;
                    end
                end
                WR_REQ: begin
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_RESP;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (bvalid) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_axi_master.sv
// Scoreboard bench for dm_axi_master: directed loads/stores against a
// configurable-latency AXI slave model.
module tb_dm_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        DM_busy;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    dm_axi_master dut (
        .clk(clk), .rst(rst),
        .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .DM_busy(DM_busy),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave configuration: wait cycles before each ready/valid.
    int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
    logic [31:0] cfg_rdata;
    logic [1:0]  cfg_rresp;

    initial begin
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                arready = arvalid && (ar_cnt == ar_wait);
                ar_cnt  = arvalid ? ar_cnt + 1 : 0;
                rvalid  = rready && (r_cnt == r_wait);
                r_cnt   = rready ? r_cnt + 1 : 0;
                rdata   = rvalid ? cfg_rdata : 32'h0;
                rresp   = rvalid ? cfg_rresp : 2'b00;
                awready = awvalid && (aw_cnt == aw_wait);
                aw_cnt  = awvalid ? aw_cnt + 1 : 0;
                wready  = wvalid && (w_cnt == w_wait);
                w_cnt   = wvalid ? w_cnt + 1 : 0;
                bvalid  = bready && (b_cnt == b_wait);
                b_cnt   = bready ? b_cnt + 1 : 0;
            end
        end
    end

    // Scoreboard queues filled at issue time.
    logic [31:0] exp_ar[$];
    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];
    logic [31:0] exp_rd[$];

    // Monitor: compares handshake payloads, read data and valid stability.
    initial begin
        logic        pend_rd = 0;
        logic        p_rst = 1;
        logic        p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0;
        logic        p_wv = 0, p_wr = 0;
        logic [31:0] p_arad = 0, p_awad = 0;
        logic [35:0] p_w = 0;
        forever begin
            @(negedge clk);
            if (pend_rd) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("mem_rdata", mem_rdata, exp_rd.pop_front());
            end
            pend_rd = rvalid && rready && !rst;
            if (!p_rst && p_arv && !p_arr) begin
                chk("ar_hold", arvalid, 1);
                chk("araddr_stable", araddr, p_arad);
            end
            if (!p_rst && p_awv && !p_awr) begin
                chk("aw_hold", awvalid, 1);
                chk("awaddr_stable", awaddr, p_awad);
            end
            if (!p_rst && p_wv && !p_wr) begin
                chk("w_hold", wvalid, 1);
                chk("w_stable", {wstrb, wdata}, p_w);
            end
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
                else chk("araddr", araddr, exp_ar.pop_front());
            end
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                else chk("awaddr", awaddr, exp_aw.pop_front());
            end
            if (wvalid && wready) begin
                if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
                else chk("wdata_wstrb", {wstrb, wdata}, exp_w.pop_front());
            end
            p_rst = rst;
            p_arv = arvalid; p_arr = arready; p_arad = araddr;
            p_awv = awvalid; p_awr = awready; p_awad = awaddr;
            p_wv = wvalid; p_wr = wready; p_w = {wstrb, wdata};
        end
    end

    always @(negedge clk)
        if (!rst) assert (!(mem_re && mem_we)) else $error("illegal re+we");

    // Per-cycle trace of the current request, index 0 = request cycle.
    logic        t_arv[64], t_awv[64], t_wv[64], t_bry[64];
    logic [31:0] t_rdat[64], t_arad[64];

    task automatic set_slave(input int a, input int r, input int aw,
                             input int w, input int b);
        ar_wait = a; r_wait = r; aw_wait = aw; w_wait = w; b_wait = b;
    endtask

    task automatic issue_load(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] resp);
        cfg_rdata = d; cfg_rresp = resp;
        mem_re = 1; mem_we = 0; mem_addr = a;
        mem_wdata = 32'h0; mem_wstrb = 4'h0;
        exp_ar.push_back(a);
        exp_rd.push_back(d);
    endtask

    task automatic issue_store(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        mem_re = 0; mem_we = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        exp_aw.push_back(a);
        exp_w.push_back({s, d});
    endtask

    // Returns in the mid-cycle of the first non-busy cycle (DONE).
    task automatic wait_done(output int busy);
        busy = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            t_arv[k] = arvalid; t_awv[k] = awvalid; t_wv[k] = wvalid;
            t_bry[k] = bready; t_rdat[k] = mem_rdata; t_arad[k] = araddr;
            if (!DM_busy) return;
            busy++;
        end
        chk("timeout", 1, 0);
    endtask

    task automatic idle_inputs();
        mem_re = 0; mem_we = 0;
    endtask

    initial begin
        int busy;
        rst = 1;
        mem_re = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        cfg_rdata = 0; cfg_rresp = 0;
        set_slave(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
        chk("rst_regs", {araddr, awaddr}, 0);
        chk("rst_wdata", {wstrb, wdata}, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_busy_idle", DM_busy, 0);
        mem_re = 1;
        #1 chk("rst_busy_req", DM_busy, 1);
        mem_re = 0;
        rst = 0;
        @(posedge clk); #2;

        // Zero-wait load
        issue_load(32'h0000_0010, 32'hDEAD_BEEF, 2'b00);
        wait_done(busy);
        idle_inputs();
        chk("t1_busy", busy, 3);
        chk("t1_arv", {t_arv[0], t_arv[1], t_arv[2]}, 3'b010);
        chk("t1_rdata_done", mem_rdata, 32'hDEAD_BEEF);

        // Store with wready delayed to cycle 4
        @(posedge clk); #2;
        set_slave(0, 0, 0, 3, 0);
        issue_store(32'h0000_0080, 32'h1234_5678, 4'b0011);
        wait_done(busy);
        idle_inputs();
        chk("t2_busy", busy, 6);
        chk("t2_awv", {t_awv[1], t_awv[2]}, 2'b10);
        chk("t2_wv", {t_wv[1], t_wv[4], t_wv[5]}, 3'b110);
        chk("t2_bready", {t_bry[4], t_bry[5]}, 2'b01);
        chk("t2_rdata_kept", mem_rdata, 32'hDEAD_BEEF);

        // Load with arready waits 3, rvalid waits 2
        @(posedge clk); #2;
        set_slave(3, 2, 0, 0, 0);
        issue_load(32'h0000_0040, 32'hCAFE_F00D, 2'b00);
        wait_done(busy);
        idle_inputs();
        chk("t3_busy", busy, 8);
        chk("t3_araddr", {t_arad[1], t_arad[4]}, {32'h40, 32'h40});
        chk("t3_arv", {t_arv[4], t_arv[5]}, 2'b10);
        chk("t3_rdata_pre", t_rdat[7], 32'hDEAD_BEEF);
        chk("t3_rdata_post", mem_rdata, 32'hCAFE_F00D);

        // Back-to-back load then store, switching inputs in DONE
        @(posedge clk); #2;
        set_slave(0, 0, 0, 0, 0);
        issue_load(32'h0000_0020, 32'h1111_2222, 2'b00);
        wait_done(busy);
        chk("t4_ld_busy", busy, 3);
        issue_store(32'h0000_0024, 32'h3333_4444, 4'hF);
        wait_done(busy);
        idle_inputs();
        chk("t4_st_busy", busy, 3);
        chk("t4_st_timing", {t_arv[1], t_awv[1], t_wv[1], t_bry[2]}, 4'b0111);
        chk("t4_rdata_kept", mem_rdata, 32'h1111_2222);

        // Reset while in WR_REQ with wvalid high
        @(posedge clk); #2;
        set_slave(0, 0, 10, 10, 0);
        issue_store(32'h0000_0100, 32'h5555_AAAA, 4'hC);
        @(negedge clk);
        @(negedge clk);
        chk("t5_wv_before", {awvalid, wvalid}, 2'b11);
        @(posedge clk); #2;
        rst = 1;
        idle_inputs();
        exp_aw.delete();
        exp_w.delete();
        @(negedge clk);
        @(negedge clk);
        chk("t5_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
        chk("t5_rdata", mem_rdata, 0);
        chk("t5_busy", DM_busy, 0);
        @(posedge clk); #2;
        rst = 0;

        // SLVERR read completes normally
        @(posedge clk); #2;
        set_slave(0, 0, 0, 0, 0);
        issue_load(32'h0000_0200, 32'hA5A5_A5A5, 2'b10);
        wait_done(busy);
        idle_inputs();
        chk("t6_busy", busy, 3);
        chk("t6_rdata", mem_rdata, 32'hA5A5_A5A5);
        repeat (5) @(negedge clk);
        chk("t6_no_retry", {arvalid, DM_busy}, 0);

        chk("sb_empty", exp_ar.size() + exp_aw.size() + exp_w.size() +
            exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
